// File: rtl/simd_alu_pipe.sv
// Two-stage packed SIMD add/sub with per-element carry isolation, optional
// saturation, sticky saturation flags and valid/ready flow control.
module simd_alu_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    input  logic [1:0]              width,
    input  logic                    sub,
    input  logic                    saturate,
    input  logic                    signed_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] c,
    output logic [LANES-1:0]        ovf,
    input  logic                    clr_sticky,
    output logic [LANES-1:0]        sat_sticky
);
    localparam int         N     = LANES * LANE_W;
    localparam logic [1:0] LOG_L = 2'($clog2(LANES));

    // Lane-index mask selecting the position of a lane inside its element.
    function automatic int elem_mask(input logic [1:0] wlog);
        return (1 << int'(wlog)) - 1;
    endfunction

    // Clamp value for one lane of an overflowing element.
    function automatic logic [LANE_W-1:0] sat_lane(input logic is_top, input logic sgn,
                                                   input logic sb, input logic a_neg);
        logic [LANE_W-1:0] v;
        if (sgn) begin
            v = a_neg ? '0 : '1;
            if (is_top) v[LANE_W-1] = a_neg;
        end else begin
            v = sb ? '0 : '1;
        end
        return v;
    endfunction

    logic             vld_p1, vld_p2;
    logic             load_p2;
    logic [1:0]       wlog_p0, wlog_p1;
    logic [N-1:0]     sum_p0, sum_p1;
    logic [LANES-1:0] ovf_p0, ovf_p1;
    logic [LANES-1:0] aneg_p0, aneg_p1;
    logic             sub_p1, sat_p1, sgn_p1;
    logic [N-1:0]     c_nx;
    logic [LANES-1:0] sticky_set;

    assign load_p2   = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || load_p2;
    assign out_valid = vld_p2;

    // ---- stage 0: carry chain broken at element boundaries, raw overflow
    always_comb begin
        int                em;
        logic              cy;
        logic [LANE_W:0]   t;
        logic [LANE_W-1:0] bx;
        logic              sa, sbx, sr;
        wlog_p0 = (width > LOG_L) ? LOG_L : width;
        em      = elem_mask(wlog_p0);
        sum_p0  = '0;
        ovf_p0  = '0;
        aneg_p0 = '0;
        cy      = 1'b0;
        t       = '0;
        bx      = '0;
        sa      = 1'b0;
        sbx     = 1'b0;
        sr      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            bx = b[i*LANE_W +: LANE_W] ^ {LANE_W{sub}};
            if ((i & em) == 0) cy = sub;
            t = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, bx} + {{LANE_W{1'b0}}, cy};
            sum_p0[i*LANE_W +: LANE_W] = t[LANE_W-1:0];
            cy         = t[LANE_W];
            aneg_p0[i] = a[i*LANE_W + LANE_W - 1];
            if (((i + 1) & em) == 0) begin
                sa        = a[i*LANE_W + LANE_W - 1];
                sbx       = bx[LANE_W-1];
                sr        = t[LANE_W-1];
                ovf_p0[i] = signed_mode ? ((sa == sbx) && (sr != sa)) : (cy ^ sub);
            end
        end
    end

    // ---- stage 1 register: raw sums, flags and the control fields of the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        vld_p1 <= 1'b0;
        else if (in_ready) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sum_p1  <= sum_p0;
            ovf_p1  <= ovf_p0;
            aneg_p1 <= aneg_p0;
            wlog_p1 <= wlog_p0;
            sub_p1  <= sub;
            sat_p1  <= saturate;
            sgn_p1  <= signed_mode;
        end
    end

    // ---- stage 1 -> 2: saturation, each lane looks at its element's top lane
    always_comb begin
        int em2;
        int top;
        c_nx = sum_p1;
        em2  = elem_mask(wlog_p1);
        top  = 0;
        for (int i = 0; i < LANES; i++) begin
            top = i | em2;
            if (sat_p1 && ovf_p1[top])
                c_nx[i*LANE_W +: LANE_W] = sat_lane(i == top, sgn_p1, sub_p1, aneg_p1[top]);
        end
    end

    assign sticky_set = (load_p2 && vld_p1 && sat_p1) ? ovf_p1 : '0;

    // ---- stage 2 register: visible result and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            c      <= '0;
            ovf    <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                c   <= c_nx;
                ovf <= ovf_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_sticky <= '0;
        else        sat_sticky <= (clr_sticky ? '0 : sat_sticky) | sticky_set;
    end

endmodule

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of lanes (power of two, 2..8).
REQ-002 The block SHALL have parameter LANE_W, default 8, giving the lane width in bits.
REQ-003 The block SHALL have the following ports, with N = LANES*LANE_W:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- a, b  in  N each  packed operands.
- width  in  2  element size: 0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes, 3 = 8 lanes; codes above log2(LANES) clamp to LANES.
- sub  in  1  0 = a+b, 1 = a-b.
- saturate  in  1  1 = clamp on overflow, 0 = wrap.
- signed_mode  in  1  1 = two's complement, 0 = unsigned.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer accepts the result.
- c  out  N  packed result.
- ovf  out  LANES  per-element overflow, reported in the bit of the element's top lane; other bits 0.
- clr_sticky  in  1  clears sat_sticky.
- sat_sticky  out  LANES  sticky saturation-event flags.

Function
REQ-004 Control fields SHALL be sampled with a, b on the accepting cycle and travel with the beat.
REQ-005 Elements SHALL be groups of 2^width adjacent lanes aligned from lane 0; carry SHALL propagate between lanes inside an element and SHALL NOT cross element boundaries.
REQ-006 Subtraction SHALL compute a + ~b + 1, with carry-in 1 into each element's lowest lane.
REQ-007 Unsigned overflow SHALL be carry-out = 1 for add and carry-out = 0 (borrow) for sub.
REQ-008 Signed overflow SHALL be operand signs equal (after inverting b for sub) and result sign different.
REQ-009 With saturate = 1, overflowing elements SHALL be clamped as follows: unsigned add to all ones; unsigned sub to 0; signed to max positive when a's sign is 0 and to min negative when it is 1.
REQ-010 With saturate = 0, results SHALL wrap; ovf SHALL be reported in both modes.
REQ-011 The datapath SHALL be two register stages: S1 holds raw sums, carries and flags; S2 holds the saturated c and ovf.
REQ-012 Latency SHALL be 2 cycles from acceptance to out_valid with no backpressure, with throughput of one beat per cycle.
REQ-013 A beat SHALL transfer only when valid and ready are both 1 on the same rising edge.
REQ-014 in_ready SHALL be !S1_valid | (!S2_valid | out_ready).
REQ-015 S2 SHALL load when !S2_valid | out_ready.
REQ-016 Stalled stages SHALL hold their data unchanged, and no beat SHALL be dropped or duplicated.
REQ-017 c and ovf SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-018 A sat_sticky bit SHALL set when a beat is loaded into S2 with saturate = 1 and the corresponding ovf bit = 1.
REQ-019 clr_sticky SHALL clear all sat_sticky bits on the next edge; on the same edge a new set SHALL win for its bit.
REQ-020 in_ready SHALL be combinational from out_ready and the stage valids; no other output SHALL be combinational from inputs.

Reset
REQ-021 While rst_n = 0, regardless of clk, the block SHALL set out_valid = 0, S1_valid = 0, c = 0, ovf = 0 and sat_sticky = 0.
REQ-022 Beats in flight at reset SHALL be discarded.
REQ-023 in_ready SHALL be 1 from the first edge after rst_n deasserts.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, with LANES = 4 and LANE_W = 8:
- width=0, add, saturate=1, signed: a=0x7F0180FF, b=0x0101FF01 -> c=0x7F028000, ovf=1010, sat_sticky=1010.
- width=1, sub, saturate=1, unsigned: a=0x0001FFFF, b=0x00020001 -> c=0x0000FFFE, ovf=1000.
- width=2, add, saturate=0, unsigned: a=0xFFFFFFFF, b=0x00000001 -> c=0x00000000, ovf=1000, sat_sticky unchanged.
- Backpressure: out_ready held 0 while 3 back-to-back beats are offered -> 2 accepted, then in_ready=0; on release the results emerge in order, one per cycle, none lost.
- Reset with S1 and S2 valid: rst_n low mid-cycle -> out_valid=0 and sat_sticky=0 immediately; no stale beat after release.
- clr_sticky=1 on the same edge as a new saturation in lane 1, with sat_sticky=0001 -> sat_sticky=0010.
